csi2_packet_parser: RTL and testbench

- Packet layer of the 4-lane MIPI CSI-2 receiver. Sits directly downstream of the four per-lane byte aligners and consumes their byte_gate, mipi_byte and hs_mode outputs.
- Merges the four lanes into 32-bit words, parses and ECC-checks the packet header, and splits traffic into short packets (frame/line sync) and long packets (payload words with byte enables, CRC stripped).

---
 rtl/csi2_pkg.sv | 36 +++
 rtl/csi2_ecc_calc.sv | 20 ++
 rtl/csi2_packet_parser.sv | 183 ++++++++++++++++++
 tb/tb_csi2_packet_parser.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// rtl/csi2_pkg.sv - shared data types, header layout and FSM encoding for the CSI-2 packet layer
package csi2_pkg;

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_LS   = 6'h02;
  localparam logic [5:0] DT_LE   = 6'h03;
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  // Bit offsets of the header fields inside the merged 32-bit lane word
  localparam int HDR_DI_LSB  = 0;
  localparam int HDR_WC_LSB  = 8;
  localparam int HDR_ECC_LSB = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DROP,
    ST_CRC,
    ST_WAIT_EOT
  } state_t;

  // Byte enables for the final payload word: rem bytes, packed from byte 0
  function automatic logic [3:0] pay_be_for_rem(input logic [15:0] rem);
    logic [3:0] be;
    case (rem)
      16'd0:   be = 4'b0000;
      16'd1:   be = 4'b0001;
      16'd2:   be = 4'b0011;
      16'd3:   be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/csi2_ecc_calc.sv
// rtl/csi2_ecc_calc.sv - combinational 24-bit to 6-bit CSI-2 packet header ECC parity
module csi2_ecc_calc (
  input  logic [23:0] hdr,
  output logic [5:0]  ecc
);

  assign ecc[0] = hdr[0] ^ hdr[1] ^ hdr[2] ^ hdr[4] ^ hdr[5] ^ hdr[7] ^ hdr[10] ^ hdr[11]
                ^ hdr[13] ^ hdr[16] ^ hdr[20] ^ hdr[21] ^ hdr[22] ^ hdr[23];
  assign ecc[1] = hdr[0] ^ hdr[1] ^ hdr[3] ^ hdr[4] ^ hdr[6] ^ hdr[8] ^ hdr[10] ^ hdr[12]
                ^ hdr[14] ^ hdr[17] ^ hdr[20] ^ hdr[21] ^ hdr[22] ^ hdr[23];
  assign ecc[2] = hdr[0] ^ hdr[2] ^ hdr[3] ^ hdr[5] ^ hdr[6] ^ hdr[9] ^ hdr[11] ^ hdr[12]
                ^ hdr[15] ^ hdr[18] ^ hdr[20] ^ hdr[21] ^ hdr[22];
  assign ecc[3] = hdr[1] ^ hdr[2] ^ hdr[3] ^ hdr[7] ^ hdr[8] ^ hdr[9] ^ hdr[13] ^ hdr[14]
                ^ hdr[15] ^ hdr[19] ^ hdr[20] ^ hdr[21] ^ hdr[23];
  assign ecc[4] = hdr[4] ^ hdr[5] ^ hdr[6] ^ hdr[7] ^ hdr[8] ^ hdr[9] ^ hdr[16] ^ hdr[17]
                ^ hdr[18] ^ hdr[19] ^ hdr[20] ^ hdr[22] ^ hdr[23];
  assign ecc[5] = hdr[10] ^ hdr[11] ^ hdr[12] ^ hdr[13] ^ hdr[14] ^ hdr[15] ^ hdr[16]
                ^ hdr[17] ^ hdr[18] ^ hdr[19] ^ hdr[21] ^ hdr[22] ^ hdr[23];

endmodule

// File: rtl/csi2_packet_parser.sv
// rtl/csi2_packet_parser.sv - 4-lane CSI-2 packet layer: header parse, short/long split; CSI2_ECC_CHECK_EN enables header ECC check
module csi2_packet_parser
  import csi2_pkg::*;
#(
  parameter logic [3:0] VC_ACCEPT   = 4'hF,
  parameter logic [5:0] MIN_LONG_DT = 6'h10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  byte_gate,
  input  logic [3:0]  hs_mode,
  input  logic [31:0] data,
  output logic        hdr_valid,
  output logic [7:0]  hdr_di,
  output logic [15:0] hdr_wc,
  output logic        pay_valid,
  output logic [31:0] pay_data,
  output logic [3:0]  pay_be,
  output logic        pay_last,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic        ecc_err,
  output logic        trunc_err
);

  state_t      state, state_nxt;
  logic [15:0] rem, rem_nxt;

  logic        hdr_valid_nxt, pay_valid_nxt, pay_last_nxt;
  logic [7:0]  hdr_di_nxt;
  logic [15:0] hdr_wc_nxt;
  logic [31:0] pay_data_nxt;
  logic [3:0]  pay_be_nxt;
  logic        fs_nxt, fe_nxt, ls_nxt, le_nxt, ecc_err_nxt, trunc_err_nxt;

  logic        word_ok, hs_done, ecc_ok, vc_ok, is_long, last_word;
  logic [7:0]  rx_di;
  logic [15:0] rx_wc;
  logic [5:0]  rx_dt;

  assign word_ok   = (byte_gate == 4'hF);
  assign hs_done   = ~&hs_mode;
  assign rx_di     = data[HDR_DI_LSB +: 8];
  assign rx_wc     = data[HDR_WC_LSB +: 16];
  assign rx_dt     = rx_di[5:0];
  assign vc_ok     = VC_ACCEPT[rx_di[7:6]];
  assign is_long   = (rx_dt >= MIN_LONG_DT);
  assign last_word = (rem <= 16'd4);

`ifdef CSI2_ECC_CHECK_EN
  logic [5:0] ecc_calc;

  csi2_ecc_calc u_ecc (
    .hdr (data[23:0]),
    .ecc (ecc_calc)
  );

  assign ecc_ok = (ecc_calc == data[HDR_ECC_LSB +: 6]);
`else
  assign ecc_ok = 1'b1;
`endif

  // Next-state and next-output decode; pulses default low, header/payload fields hold
  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    hdr_valid_nxt = 1'b0;
    hdr_di_nxt    = hdr_di;
    hdr_wc_nxt    = hdr_wc;
    pay_valid_nxt = 1'b0;
    pay_data_nxt  = pay_data;
    pay_be_nxt    = 4'h0;
    pay_last_nxt  = 1'b0;
    fs_nxt        = 1'b0;
    fe_nxt        = 1'b0;
    ls_nxt        = 1'b0;
    le_nxt        = 1'b0;
    ecc_err_nxt   = 1'b0;
    trunc_err_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (word_ok && !hs_done) begin
          if (!ecc_ok) begin
            ecc_err_nxt = 1'b1;
            state_nxt   = ST_WAIT_EOT;
          end else if (!vc_ok) begin
            rem_nxt   = rx_wc;
            state_nxt = is_long ? ST_DROP : ST_WAIT_EOT;
          end else begin
            hdr_valid_nxt = 1'b1;
            hdr_di_nxt    = rx_di;
            hdr_wc_nxt    = rx_wc;
            if (is_long) begin
              rem_nxt   = rx_wc;
              state_nxt = (rx_wc == 16'd0) ? ST_CRC : ST_PAYLOAD;
            end else begin
              fs_nxt    = (rx_dt == DT_FS);
              fe_nxt    = (rx_dt == DT_FE);
              ls_nxt    = (rx_dt == DT_LS);
              le_nxt    = (rx_dt == DT_LE);
              state_nxt = ST_WAIT_EOT;
            end
          end
        end
      end
      ST_PAYLOAD, ST_DROP: begin
        if (hs_done) begin
          trunc_err_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end else if (word_ok) begin
          if (state == ST_PAYLOAD) begin
            pay_valid_nxt = 1'b1;
            pay_data_nxt  = data;
            pay_be_nxt    = pay_be_for_rem(rem);
            pay_last_nxt  = last_word;
          end
          rem_nxt = last_word ? 16'd0 : rem - 16'd4;
          // A 3- or 4-byte tail leaves no room for the CRC, which then follows as its own word
          if (last_word) state_nxt = (rem >= 16'd3) ? ST_CRC : ST_WAIT_EOT;
        end
      end
      ST_CRC: begin
        if (hs_done) begin
          trunc_err_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end else if (word_ok) begin
          state_nxt = ST_WAIT_EOT;
        end
      end
      ST_WAIT_EOT: begin
        if (hs_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and remaining byte count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      rem   <= 16'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Registered outputs, one cycle after the accepted word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdr_valid   <= 1'b0;
      hdr_di      <= 8'h0;
      hdr_wc      <= 16'h0;
      pay_valid   <= 1'b0;
      pay_data    <= 32'h0;
      pay_be      <= 4'h0;
      pay_last    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      ecc_err     <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      hdr_valid   <= hdr_valid_nxt;
      hdr_di      <= hdr_di_nxt;
      hdr_wc      <= hdr_wc_nxt;
      pay_valid   <= pay_valid_nxt;
      pay_data    <= pay_data_nxt;
      pay_be      <= pay_be_nxt;
      pay_last    <= pay_last_nxt;
      frame_start <= fs_nxt;
      frame_end   <= fe_nxt;
      line_start  <= ls_nxt;
      line_end    <= le_nxt;
      ecc_err     <= ecc_err_nxt;
      trunc_err   <= trunc_err_nxt;
    end
  end

endmodule

// File: tb/tb_csi2_packet_parser.sv
// tb/tb_csi2_packet_parser.sv - self-checking bench for csi2_packet_parser with a packet-level model
module tb_csi2_packet_parser;
  import csi2_pkg::*;

  typedef struct packed {
    logic        hv;
    logic [7:0]  di;
    logic [15:0] wc;
    logic        pv;
    logic [31:0] pd;
    logic [3:0]  be;
    logic        pl;
    logic        fs, fe, ls, le, ee, te;
  } obs_t;

  localparam logic [3:0] VC_B = 4'h1;
  // ECC syndrome column of each header bit, bit 23 first
  localparam logic [143:0] ECC_COLS = {
    6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
    6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
    6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07};

  logic clk = 1'b0;
  logic rstn;
  logic [3:0] byte_gate, hs_mode;
  logic [31:0] data;

  logic a_hdr_valid, a_pay_valid, a_pay_last, a_fs, a_fe, a_ls, a_le, a_ecc_err, a_trunc_err;
  logic [7:0] a_hdr_di;
  logic [15:0] a_hdr_wc;
  logic [31:0] a_pay_data;
  logic [3:0] a_pay_be;
  logic b_hdr_valid, b_pay_valid, b_pay_last, b_fs, b_fe, b_ls, b_le, b_ecc_err, b_trunc_err;
  logic [7:0] b_hdr_di;
  logic [15:0] b_hdr_wc;
  logic [31:0] b_pay_data;
  logic [3:0] b_pay_be;

  obs_t act_a, act_b, exp_next, exp_cur;
  logic rej_next, rej_cur;
  int checks = 0;
  int failures = 0;
  logic [31:0] pw [16];

  always #5 clk = ~clk;

  csi2_packet_parser dut (
    .clk(clk), .rstn(rstn), .byte_gate(byte_gate), .hs_mode(hs_mode), .data(data),
    .hdr_valid(a_hdr_valid), .hdr_di(a_hdr_di), .hdr_wc(a_hdr_wc),
    .pay_valid(a_pay_valid), .pay_data(a_pay_data), .pay_be(a_pay_be), .pay_last(a_pay_last),
    .frame_start(a_fs), .frame_end(a_fe), .line_start(a_ls), .line_end(a_le),
    .ecc_err(a_ecc_err), .trunc_err(a_trunc_err));

  csi2_packet_parser #(.VC_ACCEPT(VC_B), .MIN_LONG_DT(6'h10)) dut_vc (
    .clk(clk), .rstn(rstn), .byte_gate(byte_gate), .hs_mode(hs_mode), .data(data),
    .hdr_valid(b_hdr_valid), .hdr_di(b_hdr_di), .hdr_wc(b_hdr_wc),
    .pay_valid(b_pay_valid), .pay_data(b_pay_data), .pay_be(b_pay_be), .pay_last(b_pay_last),
    .frame_start(b_fs), .frame_end(b_fe), .line_start(b_ls), .line_end(b_le),
    .ecc_err(b_ecc_err), .trunc_err(b_trunc_err));

  assign act_a = {a_hdr_valid, a_hdr_di, a_hdr_wc, a_pay_valid, a_pay_data, a_pay_be, a_pay_last,
                  a_fs, a_fe, a_ls, a_le, a_ecc_err, a_trunc_err};
  assign act_b = {b_hdr_valid, b_hdr_di, b_hdr_wc, b_pay_valid, b_pay_data, b_pay_be, b_pay_last,
                  b_fs, b_fe, b_ls, b_le, b_ecc_err, b_trunc_err};

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [5:0] bench_ecc(input logic [23:0] h);
    logic [143:0] cols;
    logic [5:0] s;
    cols = ECC_COLS;
    s = 6'h0;
    for (int i = 0; i < 24; i++) if (h[i]) s = s ^ cols[i*6 +: 6];
    return s;
  endfunction

  function automatic logic ecc_ok_m(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
    logic [5:0] syn;
    syn = bench_ecc({wc, di});
`ifdef CSI2_ECC_CHECK_EN
    return ecc[5:0] == syn;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [3:0] be_m(input int nbytes);
    int t;
    t = (1 << nbytes) - 1;
    return t[3:0];
  endfunction

  // Expected outputs follow the inputs by one clock
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_cur <= '0;
      rej_cur <= 1'b0;
    end else begin
      exp_cur <= exp_next;
      rej_cur <= rej_next;
    end
  end

  task automatic cmp_inst(input string inst, input obs_t e, input obs_t a);
    chk({inst, ".hdr_valid"}, a.hv, e.hv);
    chk({inst, ".pay_valid"}, a.pv, e.pv);
    chk({inst, ".pay_last"}, a.pl, e.pl);
    chk({inst, ".frame_start"}, a.fs, e.fs);
    chk({inst, ".frame_end"}, a.fe, e.fe);
    chk({inst, ".line_start"}, a.ls, e.ls);
    chk({inst, ".line_end"}, a.le, e.le);
    chk({inst, ".ecc_err"}, a.ee, e.ee);
    chk({inst, ".trunc_err"}, a.te, e.te);
    if (e.hv) begin
      chk({inst, ".hdr_di"}, a.di, e.di);
      chk({inst, ".hdr_wc"}, a.wc, e.wc);
    end
    if (e.pv) begin
      chk({inst, ".pay_data"}, a.pd, e.pd);
      chk({inst, ".pay_be"}, a.be, e.be);
    end
  endtask

  // Every cycle: both instances against the model
  always @(negedge clk) begin : cmp_blk
    obs_t eb;
    eb = exp_cur;
    if (rej_cur) begin
      eb.hv = 1'b0; eb.di = 8'h0; eb.wc = 16'h0;
      eb.pv = 1'b0; eb.pd = 32'h0; eb.be = 4'h0; eb.pl = 1'b0;
      eb.fs = 1'b0; eb.fe = 1'b0; eb.ls = 1'b0; eb.le = 1'b0;
    end
    cmp_inst("a", exp_cur, act_a);
    cmp_inst("b", eb, act_b);
  end

  task automatic drive(input logic [3:0] g, input logic [3:0] h, input logic [31:0] d,
                       input obs_t e, input logic rej);
    @(posedge clk);
    #1;
    byte_gate = g;
    hs_mode   = h;
    data      = d;
    exp_next  = e;
    rej_next  = rej;
  endtask

  // One HS burst: header, nwords words from pw[], then EoT. trunc_at drops hs_mode[2] with that word.
  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                          input int nwords, input int trunc_at, input bit gaps);
    obs_t e;
    logic ok, lng, rej, truncated;
    logic [3:0] vcm;
    int npay, nact, nb;
    vcm = VC_B;
    ok  = ecc_ok_m(di, wc, ecc);
    lng = (di[5:0] >= 6'h10);
    rej = !vcm[di[7:6]];
    npay = (int'(wc) + 3) / 4;
    nact = npay + ((((wc % 4) == 0) || ((wc % 4) == 3)) ? 1 : 0);
    truncated = 1'b0;
    e = '0;
    if (!ok) e.ee = 1'b1;
    else begin
      e.hv = 1'b1; e.di = di; e.wc = wc;
      if (!lng) begin
        e.fs = (di[5:0] == 6'h00);
        e.fe = (di[5:0] == 6'h01);
        e.ls = (di[5:0] == 6'h02);
        e.le = (di[5:0] == 6'h03);
      end
    end
    drive(4'hF, 4'hF, {ecc, wc[15:8], wc[7:0], di}, e, rej);
    for (int k = 0; k < nwords; k++) begin
      if (gaps && (k % 2 == 1)) drive(4'h7, 4'hF, 32'hDEADBEEF, '0, rej);
      e = '0;
      if (k == trunc_at) begin
        e.te = ok && lng && (k < nact);
        truncated = 1'b1;
        drive(4'hF, 4'hB, pw[k], e, rej);
        break;
      end
      if (ok && lng && (k < npay)) begin
        nb = int'(wc) - 4 * k;
        if (nb > 4) nb = 4;
        e.pv = 1'b1; e.pd = pw[k]; e.be = be_m(nb); e.pl = (k == npay - 1);
      end
      drive(4'hF, 4'hF, pw[k], e, rej);
    end
    e = '0;
    e.te = !truncated && ok && lng && (nwords < nact);
    drive(4'h0, 4'h0, 32'h0, e, rej);
    drive(4'h0, 4'h0, 32'h0, '0, rej);
  endtask

  initial begin
    obs_t e;
    rstn = 1'b0; byte_gate = 4'h0; hs_mode = 4'h0; data = 32'h0;
    exp_next = '0; rej_next = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.a", act_a, 80'h0);
    chk("reset.b", act_b, 80'h0);
    rstn = 1'b1;

    chk("pin.ecc_fs", bench_ecc(24'h000100), 80'h1A);
    chk("pin.ecc_raw8", bench_ecc(24'h00062A), 80'h2F);
    chk("pin.be_tail2", be_m(2), 80'h3);
    chk("pin.be_tail1", be_m(1), 80'h1);
    chk("pin.be_full", be_m(4), 80'hF);

    send_pkt(8'h00, 16'h0001, 8'h1A, 0, -1, 1'b0);
    pw[0] = 32'h44332211; pw[1] = 32'hAAAA6655; pw[2] = 32'h12345678;
    send_pkt({2'b00, DT_RAW8}, 16'd6, 8'h2F, 3, -1, 1'b0);
    pw[0] = 32'h03020100; pw[1] = 32'h07060504; pw[2] = 32'hC5C4C3C2; pw[3] = 32'h99999999;
    send_pkt({2'b00, DT_RAW8}, 16'd8, {2'b00, bench_ecc({16'd8, 8'h2A})}, 4, -1, 1'b0);
    send_pkt({2'b00, DT_RAW8}, 16'd0, {2'b00, bench_ecc({16'd0, 8'h2A})}, 2, -1, 1'b0);
    pw[0] = 32'h44332211; pw[1] = 32'hAAAA6655;
    send_pkt({2'b00, DT_RAW8}, 16'd6, 8'h2E, 2, -1, 1'b0);
    send_pkt(8'h02, 16'd5, {2'b00, bench_ecc({16'd5, 8'h02})}, 1, -1, 1'b0);
    for (int i = 0; i < 16; i++) pw[i] = 32'h10101010 * (i + 1);
    send_pkt({2'b00, DT_RAW8}, 16'd16, {2'b00, bench_ecc({16'd16, 8'h2A})}, 5, 1, 1'b0);
    send_pkt(8'h01, 16'h0022, {2'b00, bench_ecc({16'h0022, 8'h01})}, 0, -1, 1'b0);
    send_pkt(8'h03, 16'h0023, {2'b00, bench_ecc({16'h0023, 8'h03})}, 1, -1, 1'b0);
    send_pkt(8'h6A, 16'd5, {2'b00, bench_ecc({16'd5, 8'h6A})}, 3, -1, 1'b0);
    send_pkt({2'b00, DT_RAW8}, 16'd10, {2'b00, bench_ecc({16'd10, 8'h2A})}, 4, -1, 1'b1);
    send_pkt(8'h05, 16'h1234, {2'b00, bench_ecc({16'h1234, 8'h05})}, 0, -1, 1'b0);
    send_pkt(8'h0F, 16'h0004, {2'b00, bench_ecc({16'h0004, 8'h0F})}, 1, -1, 1'b0);
    send_pkt(8'h10, 16'd3, {2'b00, bench_ecc({16'd3, 8'h10})}, 2, -1, 1'b0);
    send_pkt({2'b00, DT_RAW8}, 16'd4, {2'b00, bench_ecc({16'd4, 8'h2A})}, 2, 1, 1'b0);
    send_pkt({2'b00, DT_RAW8}, 16'd2, {2'b00, bench_ecc({16'd2, 8'h2A})}, 2, 1, 1'b0);
    send_pkt({2'b00, DT_RAW8}, 16'd12, {2'b00, bench_ecc({16'd12, 8'h2A})}, 1, -1, 1'b0);
    send_pkt(8'h6A, 16'd9, {2'b00, bench_ecc({16'd9, 8'h6A})}, 1, -1, 1'b0);

    // Reset asserted while a long packet is mid-payload
    e = '0; e.hv = 1'b1; e.di = 8'h2A; e.wc = 16'd16;
    drive(4'hF, 4'hF, {2'b00, bench_ecc({16'd16, 8'h2A}), 16'd16, 8'h2A}, e, 1'b0);
    e = '0; e.pv = 1'b1; e.pd = pw[0]; e.be = 4'hF;
    drive(4'hF, 4'hF, pw[0], e, 1'b0);
    @(posedge clk);
    #1;
    chk("rst.pre_pay_valid", a_pay_valid, 80'h1);
    rstn = 1'b0; byte_gate = 4'h0; exp_next = '0; rej_next = 1'b0;
    #1;
    chk("rst.async_a", act_a, 80'h0);
    chk("rst.async_b", act_b, 80'h0);
    repeat (2) @(posedge clk);
    #1;
    hs_mode = 4'hF;
    rstn = 1'b1;
    send_pkt(8'h00, 16'h0001, 8'h1A, 0, -1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
